// File: rtl/i2s_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module      : i2s_tx_serializer
// Description : Philips I2S transmitter with a one-frame L/R sample buffer;
//               sends a silent frame and pulses underrun when starved.
// Revision    : 1.0
// ============================================================================
module i2s_tx_serializer #(
    parameter int BCLK_DIV  = 4,
    parameter int SLOT_BITS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic        i2s_bclk,
    output logic        i2s_lrclk,
    output logic        i2s_sdata,
    output logic        underrun
);

    localparam int c_frame_bits = 2 * SLOT_BITS;
    localparam int c_pad_bits   = SLOT_BITS - 16;
    localparam int c_div_w      = $clog2(BCLK_DIV);
    localparam int c_k_w        = $clog2(c_frame_bits);

    logic [c_div_w-1:0]      r_div_cnt;
    logic                    r_bclk;
    logic [c_k_w-1:0]        r_k;
    logic                    r_lrclk;
    logic                    r_sdata;
    logic                    r_underrun;
    logic [c_frame_bits-1:0] r_frame;
    logic [15:0]             r_buf_l;
    logic [15:0]             r_buf_r;
    logic                    r_vld_l;
    logic                    r_vld_r;

    logic                    w_div_wrap;
    logic                    w_fall;
    logic                    w_last_k;
    logic                    w_load;
    logic                    w_full;
    logic                    w_accept;
    logic [c_k_w-1:0]        w_k_next;
    logic [c_k_w-1:0]        w_bit_idx;
    logic                    w_lrclk_next;
    logic                    w_sdata_next;
    logic [c_frame_bits-1:0] w_frame;

    generate
        if (c_pad_bits > 0) begin : g_pad
            assign w_frame = {r_buf_l, {c_pad_bits{1'b0}}, r_buf_r, {c_pad_bits{1'b0}}};
        end else begin : g_nopad
            assign w_frame = {r_buf_l, r_buf_r};
        end
    endgenerate

    assign w_div_wrap = (r_div_cnt == c_div_w'(BCLK_DIV - 1));
    assign w_fall     = w_div_wrap & r_bclk;
    assign w_last_k   = (r_k == c_k_w'(c_frame_bits - 1));
    assign w_load     = w_fall & w_last_k;
    assign w_full     = r_vld_l & r_vld_r;
    // A full buffer always empties on the load edge, so it may take a word then.
    assign s_ready    = ~w_full | w_load;
    assign w_accept   = s_valid & s_ready;

    assign w_k_next     = w_last_k ? '0 : r_k + c_k_w'(1);
    assign w_lrclk_next = (w_k_next >= c_k_w'(SLOT_BITS));
    // Slot k carries frame bit (2*SLOT_BITS - k); k = 0 replays bit 0 of the old frame.
    assign w_bit_idx    = c_k_w'(c_frame_bits - 1) - (w_k_next - c_k_w'(1));
    assign w_sdata_next = (w_k_next == '0) ? r_frame[0] : r_frame[w_bit_idx];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div_cnt <= '0;
            r_bclk    <= 1'b0;
        end else if (w_div_wrap) begin
            r_div_cnt <= '0;
            r_bclk    <= ~r_bclk;
        end else begin
            r_div_cnt <= r_div_cnt + c_div_w'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_k       <= c_k_w'(c_frame_bits - 1);
            r_lrclk   <= 1'b1;
            r_sdata   <= 1'b0;
        end else if (w_fall) begin
            r_k       <= w_k_next;
            r_lrclk   <= w_lrclk_next;
            r_sdata   <= w_sdata_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_frame    <= '0;
            r_underrun <= 1'b0;
        end else begin
            r_underrun <= w_load & ~w_full;
            if (w_load) begin
                r_frame <= w_full ? w_frame : '0;
            end
        end
    end

    // A lone left word survives an underrun so L/R pairing never slips.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_buf_l <= '0;
            r_buf_r <= '0;
            r_vld_l <= 1'b0;
            r_vld_r <= 1'b0;
        end else if (w_load && w_full) begin
            r_vld_r <= 1'b0;
            r_vld_l <= w_accept;
            if (w_accept) begin
                r_buf_l <= s_data;
            end
        end else if (w_accept) begin
            if (!r_vld_l) begin
                r_buf_l <= s_data;
                r_vld_l <= 1'b1;
            end else begin
                r_buf_r <= s_data;
                r_vld_r <= 1'b1;
            end
        end
    end

    assign i2s_bclk  = r_bclk;
    assign i2s_lrclk = r_lrclk;
    assign i2s_sdata = r_sdata;
    assign underrun  = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_i2s_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2s_tx_serializer
// Description : Scoreboard bench; a serial-line decoder rebuilds each frame.
// Revision    : 1.0
// ============================================================================
module tb_i2s_tx_serializer;

    localparam int c_div_a  = 2;
    localparam int c_slot_a = 16;
    localparam int c_div_b  = 3;
    localparam int c_slot_b = 24;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] s_data_a, s_data_b;
    logic        s_valid_a, s_valid_b;
    logic        s_ready_a, s_ready_b;
    logic        bclk_a, lrclk_a, sdata_a, underrun_a;
    logic        bclk_b, lrclk_b, sdata_b, underrun_b;

    i2s_tx_serializer #(.BCLK_DIV(c_div_a), .SLOT_BITS(c_slot_a)) u_dut_a (
        .clk(clk), .rst(rst), .s_data(s_data_a), .s_valid(s_valid_a), .s_ready(s_ready_a),
        .i2s_bclk(bclk_a), .i2s_lrclk(lrclk_a), .i2s_sdata(sdata_a), .underrun(underrun_a)
    );

    i2s_tx_serializer #(.BCLK_DIV(c_div_b), .SLOT_BITS(c_slot_b)) u_dut_b (
        .clk(clk), .rst(rst), .s_data(s_data_b), .s_valid(s_valid_b), .s_ready(s_ready_b),
        .i2s_bclk(bclk_b), .i2s_lrclk(lrclk_b), .i2s_sdata(sdata_b), .underrun(underrun_b)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] l;
        logic [15:0] r;
        logic [31:0] exp_frame;
    } vec_t;

    vec_t        tbl[5];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] q_a[$];
    logic [31:0] q_b[$];
    int          e[2], lo_cnt[2], fs_cnt[2], ur_cnt[2], dec_cnt[2], dec_ur[2], match_cnt[2];
    bit          act[2], pend_ur[2], fr_ur[2];
    logic [63:0] sh[2];
    logic        prev_bclk[2], prev_lr[2], prev_sd[2];

    task automatic chk(input string name, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got timeout/empty required event", name);
    endtask

    task automatic sb_push(input int idx, input logic [31:0] exp);
        if (idx == 0) q_a.push_back(exp);
        else          q_b.push_back(exp);
    endtask

    // Decodes the serial line of one DUT: bits are taken on BCLK rising edges.
    task automatic mon(input int idx, input int slot, input logic bclk, input logic lr,
                       input logic sd, input logic ur);
        logic [15:0] fl;
        logic [15:0] fr;
        logic        pad;
        logic [31:0] exp;
        if (!rst) begin
            e[idx] = 0; act[idx] = 0; pend_ur[idx] = 0; fr_ur[idx] = 0; lo_cnt[idx] = 0;
            sh[idx] = '0; prev_bclk[idx] = bclk; prev_lr[idx] = 1'b1; prev_sd[idx] = sd;
            if (idx == 0) q_a.delete();
            else          q_b.delete();
        end else begin
            if (ur) begin
                pend_ur[idx] = 1'b1;
                ur_cnt[idx]++;
            end
            if (sd !== prev_sd[idx])
                chk($sformatf("sdata_changes_on_fall_%0d", idx), longint'(prev_bclk[idx] & ~bclk), 1);
            if (!prev_bclk[idx] && bclk) begin
                sh[idx] = {sh[idx][62:0], sd};
                if (act[idx]) e[idx]++;
                if (act[idx] && e[idx] == 2 * slot) begin
                    fl = '0; fr = '0; pad = 1'b0;
                    for (int m = 1; m <= 16; m++) begin
                        fl[16-m] = sh[idx][2*slot-m];
                        fr[16-m] = sh[idx][slot-m];
                    end
                    for (int m = 17; m <= slot; m++)
                        pad = pad | sh[idx][2*slot-m] | sh[idx][slot-m];
                    dec_cnt[idx]++;
                    chk($sformatf("lrclk_low_bclks_%0d", idx), lo_cnt[idx], slot);
                    if (slot > 16) chk($sformatf("slot_padding_zero_%0d", idx), pad, 0);
                    if (fr_ur[idx]) begin
                        dec_ur[idx]++;
                        chk($sformatf("underrun_frame_silent_%0d", idx), {fl, fr}, 0);
                    end else if ((idx == 0 ? q_a.size() : q_b.size()) == 0) begin
                        fail($sformatf("unexpected_frame_%0d", idx));
                    end else begin
                        exp = (idx == 0) ? q_a.pop_front() : q_b.pop_front();
                        if ({fl, fr} == exp) match_cnt[idx]++;
                        chk($sformatf("frame_data_%0d", idx), {fl, fr}, exp);
                    end
                end
                if (!lr && prev_lr[idx]) begin
                    if (act[idx]) chk($sformatf("lrclk_period_%0d", idx), e[idx], 2 * slot);
                    e[idx] = 0; act[idx] = 1'b1; fr_ur[idx] = pend_ur[idx];
                    pend_ur[idx] = 1'b0; fs_cnt[idx]++; lo_cnt[idx] = 0;
                end
                if (act[idx] && !lr) lo_cnt[idx]++;
                prev_lr[idx] = lr;
            end
            prev_bclk[idx] = bclk;
            prev_sd[idx]   = sd;
        end
    endtask

    always @(negedge clk) begin
        mon(0, c_slot_a, bclk_a, lrclk_a, sdata_a, underrun_a);
        mon(1, c_slot_b, bclk_b, lrclk_b, sdata_b, underrun_b);
    end

    task automatic push_word(input int idx, input logic [15:0] w);
        bit rdy;
        bit done;
        done = 1'b0;
        if (idx == 0) begin s_data_a = w; s_valid_a = 1'b1; end
        else          begin s_data_b = w; s_valid_b = 1'b1; end
        for (int c = 0; c < 800 && !done; c++) begin
            #1;
            rdy = (idx == 0) ? s_ready_a : s_ready_b;
            @(posedge clk);
            if (rdy) done = 1'b1;
            @(negedge clk);
        end
        if (!done) fail("push_timeout");
    endtask

    task automatic idle(input int idx);
        if (idx == 0) s_valid_a = 1'b0;
        else          s_valid_b = 1'b0;
    endtask

    task automatic push_pair(input int idx, input vec_t v);
        push_word(idx, v.l);
        push_word(idx, v.r);
        sb_push(idx, v.exp_frame);
    endtask

    task automatic wait_fs(input int idx, input int target);
        int c;
        c = 0;
        while (fs_cnt[idx] < target && c < 4000) begin
            @(negedge clk); #1;
            c++;
        end
        if (fs_cnt[idx] < target) fail("frame_start_timeout");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int na, nb, base, m0, u0, r0;
        tbl[0] = '{l: 16'hA5C3, r: 16'h1234, exp_frame: 32'hA5C3_1234};
        tbl[1] = '{l: 16'h7FFF, r: 16'h8000, exp_frame: 32'h7FFF_8000};
        tbl[2] = '{l: 16'h0F0F, r: 16'hF0F0, exp_frame: 32'h0F0F_F0F0};
        tbl[3] = '{l: 16'h8001, r: 16'h0001, exp_frame: 32'h8001_0001};
        tbl[4] = '{l: 16'h0000, r: 16'hFFFF, exp_frame: 32'h0000_FFFF};

        // Reset held with s_valid toggling
        rst = 1'b0; s_valid_a = 1'b0; s_valid_b = 1'b0; s_data_a = '0; s_data_b = '0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            s_valid_a = ~s_valid_a; s_valid_b = ~s_valid_b;
            s_data_a = 16'(i * 4097); s_data_b = 16'(i * 257);
        end
        #1;
        chk("reset_bclk", bclk_a, 0);
        chk("reset_lrclk", lrclk_a, 1);
        chk("reset_sdata", sdata_a, 0);
        chk("reset_underrun", underrun_a, 0);
        chk("reset_s_ready", s_ready_a, 1);
        chk("reset_lrclk_b", lrclk_b, 1);
        @(negedge clk);
        s_valid_a = 1'b0; s_valid_b = 1'b0;
        rst = 1'b1;
        na = 0; nb = 0;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            if (na == 0 && bclk_a) na = c;
            if (nb == 0 && bclk_b) nb = c;
        end
        chk("first_bclk_rise_a", na, c_div_a);
        chk("first_bclk_rise_b", nb, c_div_b);

        // Frame 0 silent with underrun, frame 1 carries A5C3/1234
        @(negedge clk);
        push_pair(0, tbl[0]);
        idle(0);
        wait_fs(0, 3);
        chk("frames_decoded", dec_cnt[0], 2);
        chk("frame0_underrun", dec_ur[0], 1);
        chk("frame1_match", match_cnt[0], 1);

        // Back-to-back table vectors
        m0 = match_cnt[0];
        for (int i = 0; i < 5; i++) push_pair(0, tbl[i]);
        idle(0);
        wait_fs(0, fs_cnt[0] + 3);
        chk("table_frames_matched", match_cnt[0] - m0, 5);
        chk("table_queue_drained", q_a.size(), 0);

        // Backpressure: s_valid held high over 16 words
        wait_fs(0, fs_cnt[0] + 1);
        base = fs_cnt[0]; m0 = match_cnt[0]; u0 = dec_ur[0];
        for (int i = 0; i < 8; i++) begin
            push_word(0, 16'(2 * i + 1));
            push_word(0, 16'(2 * i + 2));
            sb_push(0, {16'(2 * i + 1), 16'(2 * i + 2)});
            if (i == 0) begin
                #1;
                chk("ready_low_after_two_words", s_ready_a, 0);
            end
        end
        idle(0);
        wait_fs(0, base + 9);
        chk("backpressure_frames", match_cnt[0] - m0, 8);
        chk("backpressure_no_gap", dec_ur[0] - u0, 1);
        chk("backpressure_queue_drained", q_a.size(), 0);

        // Lone left word, then its right partner
        wait_fs(0, fs_cnt[0] + 1);
        base = fs_cnt[0]; m0 = match_cnt[0]; u0 = dec_ur[0]; r0 = ur_cnt[0];
        push_word(0, tbl[1].l);
        idle(0);
        wait_fs(0, base + 1);
        chk("underrun_pulse_lone_left", ur_cnt[0] - r0, 1);
        push_word(0, tbl[1].r);
        idle(0);
        sb_push(0, tbl[1].exp_frame);
        wait_fs(0, base + 3);
        chk("lone_left_underrun_frames", dec_ur[0] - u0, 2);
        chk("lone_left_pair_sent", match_cnt[0] - m0, 1);

        // Reset in the middle of a frame at k = 10
        wait_fs(0, fs_cnt[0] + 1);
        push_word(0, 16'hFFFF);
        push_word(0, 16'h2222);
        sb_push(0, 32'hFFFF_2222);
        push_word(0, 16'h5555);
        idle(0);
        wait_fs(0, fs_cnt[0] + 1);
        na = 0;
        while (e[0] != 10 && na < 200) begin
            @(negedge clk); #1;
            na++;
        end
        if (e[0] != 10) fail("reach_k10_timeout");
        #1 rst = 1'b0;
        #1;
        chk("midreset_bclk", bclk_a, 0);
        chk("midreset_lrclk", lrclk_a, 1);
        chk("midreset_sdata", sdata_a, 0);
        chk("midreset_underrun", underrun_a, 0);
        chk("midreset_s_ready", s_ready_a, 1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        base = fs_cnt[0]; m0 = match_cnt[0]; u0 = dec_ur[0];
        wait_fs(0, base + 1);
        push_pair(0, tbl[2]);
        idle(0);
        wait_fs(0, base + 3);
        chk("post_reset_underrun_frame", dec_ur[0] - u0, 1);
        chk("post_reset_pair", match_cnt[0] - m0, 1);
        chk("post_reset_queue_drained", q_a.size(), 0);

        // 24-bit slots on the second instance
        wait_fs(1, fs_cnt[1] + 1);
        base = fs_cnt[1]; m0 = match_cnt[1]; u0 = dec_ur[1];
        push_pair(1, tbl[3]);
        idle(1);
        wait_fs(1, base + 2);
        chk("slot24_pair", match_cnt[1] - m0, 1);
        chk("slot24_underrun_frame", dec_ur[1] - u0, 1);
        chk("slot24_queue_drained", q_b.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
